// File: rtl/ex_iter_alu.sv
// ex_iter_alu: registered execute stage with logic ops, shifts and an
// iterative restoring divider (signed DIV / unsigned DIVU).
// Single-cycle ops complete in one cycle. A division holds stall_o high
// until its result is registered. Define EX_ROTATE_EN to add the ROTR op (9).
module ex_iter_alu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rem_o,
  output logic              valid_o,
  output logic              stall_o
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
`ifdef EX_ROTATE_EN
  localparam logic [3:0] OP_ROTR = 4'd9;
`endif

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] quot_q, quot_d;      // dividend shifts out, quotient shifts in
  logic [DATA_W-1:0] part_q, part_d;      // partial remainder
  logic [DATA_W-1:0] dvsr_q, dvsr_d;      // divisor magnitude
  logic [SH_W-1:0]   cnt_q, cnt_d;        // remaining quotient bits - 1
  logic              qneg_q, qneg_d;      // negate quotient in FIX
  logic              rneg_q, rneg_d;      // negate remainder in FIX
  logic [ADDR_W-1:0] wd_lat_q, wd_lat_d;
  logic              wreg_lat_q, wreg_lat_d;

  logic [ADDR_W-1:0] wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              valid_q, valid_d;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_res;
  logic              is_div;
  logic              is_signed;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   shifted;
  logic              q_bit;

  assign shamt = reg1_i[SH_W-1:0];

  // Result of the single-cycle ops; unknown op codes give zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    alu_res = '0;
    case (aluop_i)
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_AND:  alu_res = reg1_i & reg2_i;
      OP_NOR:  alu_res = ~(reg1_i | reg2_i);
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_SLL:  alu_res = reg2_i << shamt;
      OP_SRL:  alu_res = reg2_i >> shamt;
      OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
`ifdef EX_ROTATE_EN
      // Left shift by (-shamt mod DATA_W); at shamt = 0 both halves equal reg2_i.
      OP_ROTR: alu_res = (reg2_i >> shamt) | (reg2_i << SH_W'(DATA_W - int'(shamt)));
`endif
      default: alu_res = '0;
    endcase
  end

  // Operand decode for a division accepted this cycle.
  always_comb begin
    is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    is_signed = (aluop_i == OP_DIV);
    a_neg     = is_signed && reg1_i[DATA_W-1];
    b_neg     = is_signed && reg2_i[DATA_W-1];
    a_mag     = a_neg ? -reg1_i : reg1_i;
    b_mag     = b_neg ? -reg2_i : reg2_i;
  end

  // One restoring step: shift the next dividend bit in and subtract if it fits.
  always_comb begin
    shifted = {part_q, quot_q[DATA_W-1]};
    q_bit   = (shifted >= {1'b0, dvsr_q});
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    quot_d     = quot_q;
    part_d     = part_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    wd_lat_d   = wd_lat_q;
    wreg_lat_d = wreg_lat_q;
    wd_d       = wd_q;
    wdata_d    = wdata_q;
    rem_d      = rem_q;
    wreg_d     = 1'b0;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush_i && valid_i) begin
          if (is_div) begin
            wd_lat_d   = wd_i;
            wreg_lat_d = wreg_i;
            if (reg2_i == '0) begin
              // Divide by zero: final values preloaded, FIX only registers them.
              quot_d  = '1;
              part_d  = reg1_i;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_FIX;
            end else if (is_signed && reg1_i == MOST_NEG && reg2_i == '1) begin
              quot_d  = MOST_NEG;
              part_d  = '0;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_FIX;
            end else begin
              quot_d  = a_mag;
              part_d  = '0;
              dvsr_d  = b_mag;
              cnt_d   = SH_W'(DATA_W - 1);
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              state_d = S_DIV;
            end
          end else begin
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = alu_res;
            rem_d   = '0;
            valid_d = 1'b1;
          end
        end
      end

      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          quot_d = {quot_q[DATA_W-2:0], q_bit};
          part_d = q_bit ? (shifted[DATA_W-1:0] - dvsr_q) : shifted[DATA_W-1:0];
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          wdata_d = qneg_q ? -quot_q : quot_q;
          rem_d   = rneg_q ? -part_q : part_q;
          wd_d    = wd_lat_q;
          wreg_d  = wreg_lat_q;
          valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; every register clears on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      quot_q     <= '0;
      part_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      wd_lat_q   <= '0;
      wreg_lat_q <= 1'b0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      wdata_q    <= '0;
      rem_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values.
      state_q    <= state_d;
      quot_q     <= quot_d;
      part_q     <= part_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      wd_lat_q   <= wd_lat_d;
      wreg_lat_q <= wreg_lat_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      rem_q      <= rem_d;
      valid_q    <= valid_d;
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign rem_o   = rem_q;
  assign valid_o = valid_q;
  assign stall_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_iter_alu.sv
// Self-checking bench for ex_iter_alu (DATA_W = 32): directed cases,
// random ops against an arithmetic reference model, flush and reset cases.
module tb_ex_iter_alu;

  localparam int W = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic [3:0]    aluop_i = '0;
  logic [W-1:0]  reg1_i = '0;
  logic [W-1:0]  reg2_i = '0;
  logic [4:0]    wd_i = '0;
  logic          wreg_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [W-1:0]  wdata_o;
  logic [W-1:0]  rem_o;
  logic          valid_o;
  logic          stall_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_rem = '0;

  ex_iter_alu #(.DATA_W(W), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .rem_o(rem_o), .valid_o(valid_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: results from arithmetic definitions of each op.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    longint p, sx;
    int sa, sb;
    p   = longint'(1) << a[4:0];
    q   = '0;
    r   = '0;
    lat = 1;
    case (op)
      4'd0: q = a | b;
      4'd1: q = a & b;
      4'd2: q = ~(a | b);
      4'd3: q = a ^ b;
      4'd4: q = 32'((longint'(b) * p) & 64'hFFFF_FFFF);
      4'd5: q = 32'(longint'(b) / p);
      4'd6: begin
        sx = longint'($signed(b));
        if (sx >= 0) q = 32'(sx / p);
        else         q = 32'(-(((-sx) + p - 1) / p));
      end
`ifdef EX_ROTATE_EN
      4'd9: for (int i = 0; i < 32; i++) q[i] = b[(i + int'(a[4:0])) % 32];
`endif
      4'd7: begin
        if (b == 0)                           begin q = '1; r = a; lat = 2; end
        else if (a == MIN_NEG && b == '1)     begin q = MIN_NEG; r = 0; lat = 2; end
        else begin
          sa = $signed(a); sb = $signed(b);
          q = 32'(sa / sb); r = 32'(sa % sb); lat = W + 2;
        end
      end
      4'd8: begin
        if (b == 0) begin q = '1; r = a; lat = 2; end
        else        begin q = a / b; r = a % b; lat = W + 2; end
      end
      default: q = '0;
    endcase
  endfunction

  // Issue one op, wait (bounded) for valid_o, check result, latency, stall and hold.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                        input bit noise);
    logic [31:0] eq, er;
    int lat, n, stalls;
    model(op, a, b, eq, er, lat);
    aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    if (noise && lat > 2) begin
      // An op presented while stalled must be ignored.
      aluop_i = 4'd0; reg1_i = $urandom; reg2_i = $urandom; valid_i = 1'b1;
    end
    n = 1; stalls = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      if (stall_o === 1'b1) stalls++;
      tick();
      n++;
      if (n == 4) valid_i = 1'b0;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check({tag, ".stall_cycles"}, 64'(stalls), 64'(lat - 1));
    check({tag, ".wdata"}, 64'(wdata_o), 64'(eq));
    check({tag, ".rem"}, 64'(rem_o), 64'(er));
    check({tag, ".wd_wreg"}, 64'({wd_o, wreg_o}), 64'({wd, wreg}));
    check({tag, ".stall_at_valid"}, 64'(stall_o), 64'(0));
    last_wdata = eq;
    last_rem   = er;
    tick();
    check({tag, ".hold"}, 64'({valid_o, wreg_o, wdata_o, rem_o}), 64'({2'b00, eq, er}));
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic [3:0]  op;
    int lat, pulses;

    // Reset state
    repeat (2) tick();
    check("reset.wdata", 64'(wdata_o), 64'(0));
    check("reset.rem", 64'(rem_o), 64'(0));
    check("reset.ctrl", 64'({wd_o, wreg_o, valid_o, stall_o}), 64'(0));
    rst = 1'b1;
    tick();

    // Directed single-cycle ops
    run_op("or",       4'd0, 32'h0000_FF00, 32'h00F0_00F0, 5'd5, 1'b1, 1'b0);
    run_op("sra",      4'd6, 32'd4,  32'h8000_0010, 5'd3, 1'b1, 1'b0);
    run_op("sll31",    4'd4, 32'd31, 32'h0000_0001, 5'd7, 1'b0, 1'b0);
    run_op("srl0",     4'd5, 32'd0,  32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0);
    run_op("nor",      4'd2, 32'h0F0F_0000, 32'h0000_F0F0, 5'd1, 1'b1, 1'b0);
    run_op("unknown",  4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd2, 1'b1, 1'b0);
    run_op("rotr",     4'd9, 32'd1, 32'h0000_0001, 5'd4, 1'b1, 1'b0);

    // Directed divisions
    run_op("div_m7_2",   4'd7, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1, 1'b0);
    run_op("divu_max16", 4'd8, 32'hFFFF_FFFF, 32'd16, 5'd11, 1'b1, 1'b1);
    run_op("divu_by0",   4'd8, 32'd123, 32'd0, 5'd12, 1'b1, 1'b0);
    run_op("div_ovf",    4'd7, MIN_NEG, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0);
    run_op("div_by0_neg",4'd7, 32'hFFFF_FF00, 32'd0, 5'd14, 1'b0, 1'b0);

    // Back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 6)); a = $urandom; b = $urandom;
      aluop_i = op; reg1_i = a; reg2_i = b; wd_i = 5'(i); wreg_i = 1'b1; valid_i = 1'b1;
      tick();
      model(op, a, b, eq, er, lat);
      check("b2b.valid_wdata", 64'({valid_o, stall_o, wdata_o}), 64'({2'b10, eq}));
      last_wdata = eq;
    end
    valid_i = 1'b0;
    tick();

    // Flush in IDLE drops the op
    aluop_i = 4'd0; reg1_i = 32'hFFFF_0000; reg2_i = 32'h1; valid_i = 1'b1; flush_i = 1'b1; wreg_i = 1'b1;
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle", 64'({valid_o, wreg_o, wdata_o}), 64'({2'b00, last_wdata}));

    // Flush during DIV aborts without a pulse
    aluop_i = 4'd7; reg1_i = 32'd1000; reg2_i = 32'd7; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (8) tick();
    check("flush_div.stall_before", 64'(stall_o), 64'(1));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_div.stall_after", 64'({stall_o, valid_o}), 64'(0));
    pulses = 0;
    repeat (40) begin tick(); if (valid_o === 1'b1) pulses++; end
    check("flush_div.no_pulse", 64'(pulses), 64'(0));
    run_op("and_after_flush", 4'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd21, 1'b1, 1'b0);

    // Flush during FIX
    aluop_i = 4'd8; reg1_i = 32'd55; reg2_i = 32'd0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("flush_fix.stall", 64'(stall_o), 64'(1));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_fix.aborted", 64'({stall_o, valid_o, wdata_o}), 64'({2'b00, last_wdata}));

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = (i % 3 == 0) ? 4'(7 + (i % 2)) : 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom), 1'($urandom), 1'(i % 5 == 0));
    end

    // Asynchronous reset mid-division clears outputs immediately
    aluop_i = 4'd8; reg1_i = 32'hAAAA_5555; reg2_i = 32'd3; valid_i = 1'b1; wd_i = 5'd31; wreg_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("rst_mid.data", 64'({wdata_o, rem_o}), 64'(0));
    check("rst_mid.ctrl", 64'({wd_o, wreg_o, valid_o, stall_o}), 64'(0));
    tick();
    rst = 1'b1;
    tick();
    run_op("xor_after_rst", 4'd3, 32'h1357_9BDF, 32'hFFFF_0000, 5'd6, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_iter_alu.md
Name: ex_iter_alu

Overview:
- Parametrised successor to the combinational execute stage. Handles logic ops, shift ops and iterative signed/unsigned division.
- All results are registered. Division is multi-cycle, and the block back-pressures the ID/EX pipeline register through stall_o.
- Sits between the ID/EX register and the EX/MEM register.
- Quotient is returned on wdata_o; remainder on rem_o for the HI/LO path.

Parameters:
DATA_W, 32, operand/result width; power of two, >= 8
ADDR_W, 5, destination register address width
SH_W, log2(DATA_W), shift-amount width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
valid_i  in  1  operation presented this cycle
aluop_i  in  4  op code: 0 OR, 1 AND, 2 NOR, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 DIV (signed), 8 DIVU, 9 ROTR (optional), others unknown
reg1_i  in  DATA_W  operand 1; dividend; shift amount in [SH_W-1:0]
reg2_i  in  DATA_W  operand 2; shifted value; divisor
wd_i  in  ADDR_W  destination register address
wreg_i  in  1  write enable for destination
flush_i  in  1  pipeline flush; aborts current/incoming op
wd_o  out  ADDR_W  registered destination address
wreg_o  out  1  registered write enable; 0 whenever valid_o = 0
wdata_o  out  DATA_W  result / quotient
rem_o  out  DATA_W  remainder for DIV/DIVU; 0 for other ops
valid_o  out  1  one-cycle pulse when result outputs are valid
stall_o  out  1  busy; upstream holds its inputs while high

Behaviour:
- Reset (rst = 0, async): state IDLE; every output 0; internal dividend, divisor, quotient, counter and sign registers 0.
- States:
  - IDLE: accepts ops.
  - DIV: one quotient bit per cycle for DATA_W cycles.
  - FIX: sign correction and output register load.
- stall_o = 1 in DIV and FIX; stall_o = 0 in IDLE.
- Single-cycle ops (0-6, 9, unknown):
  - Accepted in IDLE when valid_i = 1.
  - Next cycle: valid_o = 1; wd_o/wreg_o follow the inputs; wdata_o = result; rem_o = 0.
  - Latency 1; back-to-back accepts every cycle.
- Shifts:
  - Amount is reg1_i[SH_W-1:0]; the value shifted is reg2_i.
  - SRA replicates reg2_i[DATA_W-1].
  - Amount 0 returns reg2_i unchanged.
- Unknown op: wdata_o = 0, valid_o still pulses, wreg_o follows wreg_i.
- DIV/DIVU accepted in IDLE:
  - Latches operand magnitudes, result signs, wd_i and wreg_i; enters DIV.
  - Restoring shift-subtract on magnitudes for DATA_W cycles, then FIX for one cycle.
  - In FIX: quotient negated if the operand signs differ (DIV only); remainder takes the dividend's sign.
  - valid_o rises the cycle after FIX; state returns to IDLE the same cycle. Total latency DATA_W + 2.
  - stall_o falls in the valid_o cycle, so the next op can be accepted then.
- Division by zero: bypasses DIV and goes straight to FIX (latency 2).
  - Quotient = all ones.
  - Remainder = reg1_i.
- Signed overflow (DIV of most-negative value by -1): quotient = most-negative value, remainder = 0. Same 2-cycle latency.
- valid_i while stall_o = 1: ignored; upstream must hold its inputs.
- Flush:
  - flush_i = 1 in IDLE: drops that cycle's input; no valid_o next cycle.
  - flush_i = 1 in DIV or FIX: returns to IDLE next cycle; no valid_o for the aborted op; stall_o drops next cycle.
  - flush_i has priority over valid_i.
- Outputs hold their last values between pulses, except wreg_o and valid_o, which are 0.
- rst deasserting mid-division: the operation is lost; the block restarts from IDLE.

Optional Feature:
- Macro EX_ROTATE_EN.
- Defined: op 9 ROTR = reg2_i rotated right by reg1_i[SH_W-1:0]; latency 1.
- Undefined: no rotator logic; op 9 is handled as unknown (wdata_o = 0, valid_o pulses).

Test Plan:
- DATA_W=32: OR 0x0000FF00 | 0x00F000F0, wd_i=5, wreg_i=1 -> next cycle valid_o=1, wdata_o=0x00F0FFF0, wd_o=5, wreg_o=1, stall_o=0 throughout.
- SRA reg2_i=0x80000010, reg1_i=4 -> wdata_o=0xF8000001. SLL of 0x1 by 31 -> 0x80000000. SRL by 0 -> operand unchanged.
- DIV -7 / 2 -> stall_o high 33 cycles, valid_o at cycle 34 after accept, wdata_o=0xFFFFFFFD, rem_o=0xFFFFFFFF. DIVU 0xFFFFFFFF / 16 -> 0x0FFFFFFF rem 0xF.
- DIVU 123 / 0 -> valid_o 2 cycles later, wdata_o=0xFFFFFFFF, rem_o=123. DIV 0x80000000 / -1 -> wdata_o=0x80000000, rem_o=0.
- Flush at cycle 10 of a DIV -> no valid_o; stall_o=0 next cycle; a following AND accepted and completed normally. Assert rst mid-division -> all outputs 0 immediately.
- EX_ROTATE_EN: ROTR 0x00000001 by 1 -> 0x80000000. Without the macro, the same stimulus -> wdata_o=0, valid_o=1.
